// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared definitions for the memory access sequencer.
// Holds the RV32 load/store funct3 codes, the FSM state encoding and the
// size/offset/crossing helpers used by the top and the load aligner.
package mem_access_ctrl_pkg;

  // RV32 funct3 codes; stores reuse the B/H/W encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Access size in bytes; only meaningful for legal funct3.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

  // offset + size > 4 means the access spills into the next word.
  function automatic logic crosses(input logic [1:0] off, input logic [2:0] size);
    return (({1'b0, off} + size) > 3'd4);
  endfunction

  // Store data with bytes beyond the access size cleared.
  function automatic logic [31:0] size_data(input logic [31:0] wdata, input logic [2:0] size);
    case (size)
      3'd1:    return {24'h0, wdata[7:0]};
      3'd2:    return {16'h0, wdata[15:0]};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// mem_access_ctrl_load_align: combinational load data extraction.
// Shifts the {B,A} word pair right by the byte offset, keeps the access
// size and sign/zero extends per funct3. The top byte of B can never reach
// the result (offset 3 word load ends at byte 6), so only 56 bits come in.
module mem_access_ctrl_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [55:0] words_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] low;

  // Byte-granular right shift then extension.
  always_comb begin
    case (offset_i)
      2'd0:    low = words_i[31:0];
      2'd1:    low = words_i[39:8];
      2'd2:    low = words_i[47:16];
      default: low = words_i[55:24];
    endcase
    case (funct3_i)
      F3_B:    result_o = {{24{low[7]}}, low[7:0]};
      F3_H:    result_o = {{16{low[15]}}, low[15:0]};
      F3_W:    result_o = low;
      F3_BU:   result_o = {24'h0, low[7:0]};
      F3_HU:   result_o = {16'h0, low[15:0]};
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer for a word-wide
// request/ack data memory. Registered outputs, one FSM.
// Build option MEM_ACCESS_MISALIGNED_EN: when defined, word-crossing accesses
// are split into two back-to-back word accesses (ACC1); when undefined they
// fault without touching memory and ACC1 logic is not built.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int WA_W = ADDR_W - 2;

  state_e            state_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              mem_req_q;
  logic [WA_W-1:0]   mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              resp_valid_q;
  logic              resp_fault_q;
  logic [31:0]       resp_rdata_q;

  logic [2:0]        req_size;
  logic [1:0]        req_off;
  logic              req_cross;
  logic              req_ok;
  logic [31:0]       st_data;
  logic [3:0]        st_mask;
  logic [31:0]       acc0_wdata;
  logic [3:0]        acc0_be;
  logic [55:0]       ld_words;
  logic [31:0]       ld_result;

`ifdef MEM_ACCESS_MISALIGNED_EN
  logic              cross_q;
  logic [31:0]       word_a_q;
  logic [31:0]       acc1_wdata_q;
  logic [3:0]        acc1_be_q;
  logic [63:0]       st_lanes;
  logic [7:0]        st_lane_mask;
`endif

  // Request decode, store lane placement and load word selection.
  always_comb begin
    req_size = access_size(req_funct3);
    req_off  = req_addr[1:0];
    req_cross = crosses(req_off, req_size);
    st_data  = size_data(req_wdata, req_size);
    st_mask  = size_mask(req_size);
`ifdef MEM_ACCESS_MISALIGNED_EN
    st_lanes     = {32'h0, st_data} << {req_off, 3'b000};
    st_lane_mask = {4'h0, st_mask} << req_off;
    acc0_wdata   = st_lanes[31:0];
    acc0_be      = st_lane_mask[3:0];
    req_ok       = f3_legal(req_we, req_funct3);
    // In ACC1 the live read word is B and A was latched on the first ack.
    ld_words     = (state_q == ST_ACC1) ? {mem_rdata[23:0], word_a_q}
                                        : {24'h0, mem_rdata};
`else
    acc0_wdata   = st_data << {req_off, 3'b000};
    acc0_be      = st_mask << req_off;
    req_ok       = f3_legal(req_we, req_funct3) & ~req_cross;
    ld_words     = {24'h0, mem_rdata};
`endif
  end

  mem_access_ctrl_load_align u_load_align (
    .words_i  (ld_words),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ld_result)
  );

  // Sequencer FSM; the response is built straight from the final ack's read
  // word so resp_valid lands the cycle after that ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'h0;
`ifdef MEM_ACCESS_MISALIGNED_EN
      cross_q      <= 1'b0;
      word_a_q     <= 32'h0;
      acc1_wdata_q <= 32'h0;
      acc1_be_q    <= 4'h0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_off;
            if (req_ok) begin
              state_q     <= ST_ACC0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= req_addr[ADDR_W-1:2];
              mem_be_q    <= req_we ? acc0_be : 4'h0;
              mem_wdata_q <= req_we ? acc0_wdata : 32'h0;
`ifdef MEM_ACCESS_MISALIGNED_EN
              cross_q      <= req_cross;
              acc1_be_q    <= req_we ? st_lane_mask[7:4] : 4'h0;
              acc1_wdata_q <= req_we ? st_lanes[63:32] : 32'h0;
`endif
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end
          end
        end
        ST_ACC0: begin
          if (mem_ack) begin
`ifdef MEM_ACCESS_MISALIGNED_EN
            if (cross_q) begin
              state_q     <= ST_ACC1;
              word_a_q    <= mem_rdata;
              mem_addr_q  <= mem_addr_q + 1'b1;
              mem_be_q    <= acc1_be_q;
              mem_wdata_q <= acc1_wdata_q;
            end else
`endif
            begin
              state_q      <= ST_RESP;
              mem_req_q    <= 1'b0;
              mem_be_q     <= 4'h0;
              mem_wdata_q  <= 32'h0;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_rdata_q <= we_q ? 32'h0 : ld_result;
            end
          end
        end
`ifdef MEM_ACCESS_MISALIGNED_EN
        ST_ACC1: begin
          if (mem_ack) begin
            state_q      <= ST_RESP;
            mem_req_q    <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= we_q ? 32'h0 : ld_result;
          end
        end
`endif
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          mem_be_q  <= 4'h0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE) & rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the pipeline's memory stage and a single-port, word-organised data memory with a request/acknowledge handshake. It accepts one load or store at a time, drives the word address, byte enables and lane-shifted write data, and waits for the memory acknowledge. It extracts and sign- or zero-extends load data, then returns a single-cycle response. It owns the memory port exclusively and, when configured, splits accesses that cross a word boundary into two back-to-back word accesses.

## Interface
- `ADDR_W`, 32, byte-address width; memory word address is `ADDR_W-2` bits.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `req_valid`  in  1  pipeline access request.
- `req_ready`  out  1  controller can accept; equals (state==IDLE) & rst.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 load/store funct3, constants from `Opcode.vh`.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle pulse; access complete.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  valid with `resp_valid`; illegal funct3 or unsupported misalignment.
- `mem_req`  out  1  memory access request, held until `mem_ack`.
- `mem_addr`  out  ADDR_W-2  word address.
- `mem_be`  out  4  byte write enables; 0 for reads.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `mem_ack`  in  1  access done; may arrive any cycle after `mem_req` rises, including the first.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: on `req_valid & req_ready`, capture the request.
  - If legal, go to ACC0.
  - If illegal, go directly to RESP with fault set.
- Legal funct3:
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
  - Anything else is illegal; it issues no memory access.
- Size: byte 1, half 2, word 4. Offset = addr[1:0]. Crossing = offset + size > 4.
- ACC0: `mem_req`=1, `mem_addr`=addr[ADDR_W-1:2].
  - Store: form 64-bit data = wdata << 8·offset and mask = ((1<<size)-1) << offset.
  - ACC0 uses the low 4 lanes of data and mask; ACC1 uses the high 4.
- On `mem_ack` in ACC0:
  - Latch `mem_rdata` as word A.
  - Go to ACC1 if crossing, else RESP.
- ACC1: `mem_addr` = ACC0 address + 1, wrapping modulo 2^(ADDR_W-2). On `mem_ack`, latch word B and go to RESP.
- Load extraction:
  - Form {B,A} >> 8·offset; B is 0 when not crossing.
  - Take the low `size` bytes and sign- or zero-extend per funct3.
  - In-word halfword at offset 1 returns bytes [23:8].
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. No response back-pressure.
- `mem_req` deasserts in the cycle after the final ack. `mem_be`/`mem_wdata` are 0 outside ACC0/ACC1.

## Timing
- Reset (rst=0 at an edge):
  - state goes to IDLE.
  - `mem_req`, `mem_be`, `mem_wdata`, `resp_valid`, `resp_fault`, `resp_rdata` go to 0.
  - `req_ready` reads 0 while rst=0.
- Reset mid-access abandons the access immediately with no response. The memory sees `mem_req` drop.
- Aligned access: accept at edge N; `mem_req` high in cycle N+1. Ack in cycle N+k gives `resp_valid` in cycle N+k+1. Minimum latency is 2 cycles from accept to response.
- Crossing access adds ack latency plus 1 cycle; ACC1 `mem_req` is asserted the cycle after the ACC0 ack.
- Fault: `resp_valid` is asserted the cycle after accept.
- `mem_ack` outside ACC0/ACC1 is ignored.
- The next request can be accepted the cycle after RESP.

## Configuration
- `MEM_ACCESS_MISALIGNED_EN` defined: crossing accesses are split as above.
- Undefined: any crossing access faults with no memory access, and ACC1 is not synthesised. In-word offsets (LH at offset 1, LB at any offset) are still supported.

## Structure
- Size, offset and crossing helpers and the state encoding go in the shared header `mem_ctrl_defs.vh`. funct3 constants stay in `Opcode.vh`.
- One sub-module, `load_align`: combinational {B,A}, offset and funct3 in, extended 32-bit result out. It is reused by a future store-forwarding path.

## Test plan
- LW 0x100, mem returns 0xDEADBEEF with ack after 3 cycles → single access to word 0x40; `resp_rdata`=0xDEADBEEF; `resp_valid` 4 cycles after accept.
- LB 0x103 on 0x80FF0000, then LBU 0x103 → 0xFFFFFF80, then 0x00000080.
- SH 0x102, wdata 0x0000ABCD → `mem_be`=1100 and `mem_wdata`=0xABCD0000; `resp_rdata`=0, fault 0.
- With macro: LW 0x103, words 0x44332211 then 0x88776655 → accesses 0x40 then 0x41; result 0x77665544. Without macro: the same request gives fault, no `mem_req`, response next cycle.
- Address wrap, macro on: SW 0xFFFFFFFE, wdata 0x11223344 → ACC0 word 0x3FFFFFFF with be 1100; ACC1 word 0x0 with be 0011 and data 0x00001122.
- funct3=3 load → fault, rdata 0. Reset during ACC0 wait → `mem_req` 0 next cycle, no `resp_valid`, `req_ready` 1 after reset is released.
